risc8_reg_dump: RTL and testbench
=================================

// Module: risc8_reg_dump
//
// PURPOSE
//   Debug read-out initiator for the risc8 register file. On a start request it
//   walks registers 0..NUM_REGS-1 through the regfile's single-byte B read port
//   (1-cycle read latency) and streams each byte on a valid/ready output with
//   its index. The debug/UART bridge on the halted core uses it to snapshot R0-R31.
//
// PARAMETERS
//   NUM_REGS   32  registers to read; 2..32
//   ADDR_BITS  6   width of regfile address (matches regfile a/b ports)
//
// PORTS
//   clk        in   1          system clock
//   reset      in   1          asynchronous, active-high reset
//   start      in   1          1-cycle request to begin a dump; ignored while busy
//   abort      in   1          terminate the dump at the next clock edge
//   busy       out  1          high from accepted start until DONE/abort
//   done       out  1          1-cycle pulse after the last byte is accepted
//   rd_en      out  1          high while this block owns the regfile B address mux
//   rd_addr    out  ADDR_BITS  register address driven to regfile b port
//   rd_data    in   8          regfile Rb; valid the cycle after rd_addr is presented
//   out_valid  out  1          out_data/out_index hold a byte
//   out_ready  in   1          sink accepts byte when out_valid && out_ready
//   out_data   out  8          register contents
//   out_index  out  5          register number of out_data
//
// BEHAVIOUR
//   Reset (async): state=IDLE, idx=0; busy, done, rd_en, out_valid = 0;
//     rd_addr, out_data, out_index = 0. Effective immediately.
//   FSM states: IDLE, ISSUE, CAPTURE, SEND, FINISH.
//   - IDLE: start=1 -> idx<=0, ISSUE, busy<=1. Otherwise stay.
//   - ISSUE: rd_en=1, rd_addr={0,idx}; -> CAPTURE next cycle.
//   - CAPTURE: rd_addr held; rd_data sampled at end of this cycle into out_data,
//     out_index<=idx, out_valid<=1; -> SEND.
//   - SEND: out_valid=1, out_data/out_index stable until handshake.
//     out_ready=1: out_valid<=0; idx==NUM_REGS-1 -> FINISH, else idx<=idx+1, ISSUE.
//     out_ready=0: hold state and data indefinitely.
//   - FINISH: done=1 one cycle, busy<=0, rd_en<=0; -> IDLE.
//   rd_en high in ISSUE, CAPTURE, SEND (SEND keeps ownership, no bus glitch).
//   Latency: start edge to first out_valid = 2 cycles; best-case 3 cycles/byte
//     with out_ready held high; full 32-byte dump = 96 cycles + FINISH.
//   out_index is idx[4:0]; idx is a 5-bit counter, no wrap: stops at NUM_REGS-1.
//   abort (any non-IDLE state): next edge -> IDLE, busy/rd_en/out_valid<=0, no
//     done pulse; an in-flight byte is discarded even if out_ready is high that
//     cycle (abort has priority over handshake). abort in IDLE: no effect.
//   start and abort same cycle in IDLE: abort wins, stay IDLE.
//   start while busy: ignored, no restart. start in FINISH cycle: ignored.
//   rd_data is not sampled in any state other than CAPTURE.
//
// TESTING
//   1. Preload R0..R31 = 0x40+n, out_ready=1, pulse start -> 32 bytes, index
//      0..31, data 0x40..0x5F, done 1 cycle after byte 31, total 97 cycles.
//   2. Backpressure: out_ready=0 for 10 cycles at index 5 -> out_data=0x45,
//      out_index=5 held stable, rd_addr=5 held; resumes with index 6.
//   3. abort during SEND of index 12 with out_ready=1 -> no handshake counted,
//      busy=0 next cycle, no done; following start restarts at index 0.
//   4. start pulsed again at index 3 -> ignored, sequence continues 4..31, single done.
//   5. Async reset asserted mid-CAPTURE (between edges) -> outputs 0 immediately,
//      IDLE; start after reset release dumps from index 0.
//   6. NUM_REGS=2: dump yields exactly indices 0,1 then done; rd_addr never exceeds 1.

Source files
------------

// File: rtl/risc8_reg_dump_if.sv
// Bus bundle between the register-dump sequencer, the regfile B read port
// and the byte sink. The dump block is the master; the debug bridge side is the slave.
interface risc8_reg_dump_if #(
  parameter int ADDR_BITS = 6
);
  logic                 start;
  logic                 abort;
  logic                 busy;
  logic                 done;
  logic                 rd_en;
  logic [ADDR_BITS-1:0] rd_addr;
  logic [7:0]           rd_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [7:0]           out_data;
  logic [4:0]           out_index;

  modport master (
    input  start, abort, rd_data, out_ready,
    output busy, done, rd_en, rd_addr, out_valid, out_data, out_index
  );

  modport slave (
    output start, abort, rd_data, out_ready,
    input  busy, done, rd_en, rd_addr, out_valid, out_data, out_index
  );
endinterface

// File: rtl/risc8_reg_dump.sv
// Debug read-out initiator: walks regfile registers 0..NUM_REGS-1 through the
// 1-cycle-latency B read port and streams each byte with its index on valid/ready.
module risc8_reg_dump #(
  parameter int NUM_REGS  = 32,
  parameter int ADDR_BITS = 6
) (
  input  logic               clk,
  input  logic               reset,
  risc8_reg_dump_if.master   bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    CAPTURE = 3'd2,
    SEND    = 3'd3,
    FINISH  = 3'd4
  } state_t;

  localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

  state_t     state_r;
  logic [4:0] idx_r;

  // Dump sequencer; every output is a register updated together with the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= IDLE;
      idx_r         <= 5'd0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.rd_en     <= 1'b0;
      bus.rd_addr   <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= 8'd0;
      bus.out_index <= 5'd0;
    end else begin
      bus.done <= 1'b0;
      // Abort beats both a pending handshake and a same-cycle start; in IDLE it changes nothing.
      if (bus.abort) begin
        state_r       <= IDLE;
        bus.busy      <= 1'b0;
        bus.rd_en     <= 1'b0;
        bus.out_valid <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            if (bus.start) begin
              idx_r       <= 5'd0;
              state_r     <= ISSUE;
              bus.busy    <= 1'b1;
              bus.rd_en   <= 1'b1;
              bus.rd_addr <= '0;
            end else begin
              state_r <= IDLE;
            end
          end
          ISSUE: begin
            state_r <= CAPTURE;
          end
          CAPTURE: begin
            bus.out_data  <= bus.rd_data;
            bus.out_index <= idx_r;
            bus.out_valid <= 1'b1;
            state_r       <= SEND;
          end
          SEND: begin
            if (bus.out_ready) begin
              bus.out_valid <= 1'b0;
              if (idx_r == LAST_IDX) begin
                state_r   <= FINISH;
                bus.done  <= 1'b1;
                bus.rd_en <= 1'b0;
              end else begin
                idx_r       <= idx_r + 5'd1;
                bus.rd_addr <= ADDR_BITS'(idx_r + 5'd1);
                state_r     <= ISSUE;
              end
            end else begin
              state_r <= SEND;
            end
          end
          FINISH: begin
            bus.busy <= 1'b0;
            state_r  <= IDLE;
          end
          default: begin
            state_r       <= IDLE;
            bus.busy      <= 1'b0;
            bus.rd_en     <= 1'b0;
            bus.out_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_risc8_reg_dump.sv
// Self-checking bench for risc8_reg_dump: transaction-level reference model,
// per-cycle compare, directed scenarios and a randomized phase.
module tb_risc8_reg_dump;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  risc8_reg_dump_if #(.ADDR_BITS(6)) b32 ();
  risc8_reg_dump_if #(.ADDR_BITS(6)) b2 ();

  risc8_reg_dump #(.NUM_REGS(32), .ADDR_BITS(6)) dut32 (.clk(clk), .reset(reset), .bus(b32));
  risc8_reg_dump #(.NUM_REGS(2),  .ADDR_BITS(6)) dut2  (.clk(clk), .reset(reset), .bus(b2));

  logic [7:0]  regs [32];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  logic [12:0] acc_q [$];
  logic [12:0] acc2_q [$];
  int          done_cnt = 0;
  int          done2_cnt = 0;
  int          max_addr2 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Regfile B ports: data for the presented address appears one cycle later.
  always @(posedge clk) begin
    b32.rd_data <= regs[b32.rd_addr[4:0]];
    b2.rd_data  <= regs[b2.rd_addr[4:0]];
  end

  // Accepted-byte and done-pulse logs, used by the directed checks.
  always @(posedge clk) begin
    if (!reset) begin
      if (b32.out_valid && b32.out_ready && !b32.abort) acc_q.push_back({b32.out_index, b32.out_data});
      if (b32.done) done_cnt <= done_cnt + 1;
      if (b2.out_valid && b2.out_ready && !b2.abort) acc2_q.push_back({b2.out_index, b2.out_data});
      if (b2.done) done2_cnt <= done2_cnt + 1;
      if (b2.rd_en && int'(b2.rd_addr) > max_addr2) max_addr2 <= int'(b2.rd_addr);
    end
  end

  // Reference model: register in flight and how many cycles since its read was issued.
  bit m_active = 1'b0;
  bit m_finish = 1'b0;
  int m_idx = 0;
  int m_age = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_active = 1'b0; m_finish = 1'b0; m_idx = 0; m_age = 0;
    end else if (m_finish) begin
      m_finish = 1'b0;
    end else if (!m_active) begin
      if (b32.start && !b32.abort) begin
        m_active = 1'b1; m_idx = 0; m_age = 0;
      end
    end else if (b32.abort) begin
      m_active = 1'b0;
    end else if (m_age < 2) begin
      m_age++;
    end else if (b32.out_ready) begin
      if (m_idx == 31) begin
        m_active = 1'b0; m_finish = 1'b1;
      end else begin
        m_idx++; m_age = 0;
      end
    end
  end

  always @(negedge clk) begin
    check("busy", 32'(b32.busy), 32'(m_active || m_finish));
    check("done", 32'(b32.done), 32'(m_finish));
    check("rd_en", 32'(b32.rd_en), 32'(m_active));
    check("out_valid", 32'(b32.out_valid), 32'(m_active && m_age == 2));
    if (m_active) check("rd_addr", 32'(b32.rd_addr), 32'(m_idx));
    if (m_active && m_age == 2) begin
      check("out_data", 32'(b32.out_data), 32'(regs[m_idx]));
      check("out_index", 32'(b32.out_index), 32'(m_idx));
    end
  end

  task automatic start32(output int t0);
    @(negedge clk);
    b32.start = 1'b1;
    @(negedge clk);
    b32.start = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_done32(output int t);
    int k = 0;
    while (!b32.done && k < 400) begin @(negedge clk); k++; end
    check("done_timeout", 32'(b32.done), 32'd1);
    t = cyc;
  endtask

  task automatic wait_valid_idx32(input int idx);
    int k = 0;
    while (!(b32.out_valid && int'(b32.out_index) == idx) && k < 400) begin @(negedge clk); k++; end
    check("valid_timeout", 32'(b32.out_valid && int'(b32.out_index) == idx), 32'd1);
  endtask

  task automatic check_full_stream(input string name);
    check({name, "_count"}, 32'(acc_q.size()), 32'd32);
    for (int k = 0; k < acc_q.size(); k++) begin
      check({name, "_idx"}, 32'(acc_q[k][12:8]), 32'(k));
      check({name, "_data"}, 32'(acc_q[k][7:0]), 32'(regs[k]));
    end
  endtask

  initial begin
    int t0, t1, d0;
    reset = 1'b1;
    b32.start = 1'b0; b32.abort = 1'b0; b32.out_ready = 1'b1;
    b2.start = 1'b0;  b2.abort = 1'b0;  b2.out_ready = 1'b1;
    for (int n = 0; n < 32; n++) regs[n] = 8'h40 + 8'(n);
    @(negedge clk);
    check("reset_busy", 32'(b32.busy), 32'd0);
    check("reset_rd_addr", 32'(b32.rd_addr), 32'd0);
    check("reset_out_data", 32'(b32.out_data), 32'd0);
    check("reset_out_index", 32'(b32.out_index), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Full dump with ready held high.
    acc_q.delete(); d0 = done_cnt;
    start32(t0);
    while (!b32.out_valid && cyc - t0 < 10) @(negedge clk);
    check("t1_first_valid_latency", 32'(cyc - t0), 32'd2);
    wait_done32(t1);
    check("t1_done_latency", 32'(t1 - t0), 32'd96);
    @(negedge clk);
    check("t1_busy_cycles", 32'(cyc - t0), 32'd97);
    check("t1_busy_low", 32'(b32.busy), 32'd0);
    check("t1_done_pulses", 32'(done_cnt - d0), 32'd1);
    check("t1_first_byte", 32'(acc_q[0]), 32'h0040);
    check("t1_last_byte", 32'(acc_q[31]), 32'h1F5F);
    check_full_stream("t1");

    // Backpressure at index 5.
    for (int n = 0; n < 32; n++) regs[n] = 8'($urandom);
    regs[5] = 8'h45;
    acc_q.delete();
    start32(t0);
    begin
      int k = 0;
      while (!(b32.rd_en && b32.rd_addr == 6'd5 && !b32.out_valid) && k < 400) begin @(negedge clk); k++; end
    end
    b32.out_ready = 1'b0;
    @(negedge clk);
    repeat (10) begin
      @(negedge clk);
      check("t2_hold_valid", 32'(b32.out_valid), 32'd1);
      check("t2_hold_data", 32'(b32.out_data), 32'h45);
      check("t2_hold_index", 32'(b32.out_index), 32'd5);
      check("t2_hold_rd_addr", 32'(b32.rd_addr), 32'd5);
    end
    b32.out_ready = 1'b1;
    wait_done32(t1);
    @(negedge clk);
    check("t2_byte5", 32'(acc_q[5]), 32'h0545);
    check_full_stream("t2");

    // Abort during SEND of index 12 while the sink is ready.
    for (int n = 0; n < 32; n++) regs[n] = 8'($urandom);
    acc_q.delete(); d0 = done_cnt;
    start32(t0);
    wait_valid_idx32(12);
    b32.abort = 1'b1;
    @(negedge clk);
    b32.abort = 1'b0;
    check("t3_busy_after_abort", 32'(b32.busy), 32'd0);
    check("t3_valid_after_abort", 32'(b32.out_valid), 32'd0);
    check("t3_rd_en_after_abort", 32'(b32.rd_en), 32'd0);
    repeat (3) @(negedge clk);
    check("t3_bytes_before_abort", 32'(acc_q.size()), 32'd12);
    check("t3_no_done", 32'(done_cnt - d0), 32'd0);
    acc_q.delete();
    start32(t0);
    wait_done32(t1);
    @(negedge clk);
    check("t3_restart_first_idx", 32'(acc_q[0][12:8]), 32'd0);
    check_full_stream("t3");

    // Start re-pulsed mid-dump is ignored.
    acc_q.delete(); d0 = done_cnt;
    start32(t0);
    wait_valid_idx32(3);
    b32.start = 1'b1;
    @(negedge clk);
    b32.start = 1'b0;
    wait_done32(t1);
    repeat (6) @(negedge clk);
    check("t4_single_done", 32'(done_cnt - d0), 32'd1);
    check("t4_no_restart", 32'(b32.busy), 32'd0);
    check_full_stream("t4");

    // Async reset in the middle of a CAPTURE cycle.
    start32(t0);
    wait_valid_idx32(7);
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("t5_busy", 32'(b32.busy), 32'd0);
    check("t5_rd_en", 32'(b32.rd_en), 32'd0);
    check("t5_rd_addr", 32'(b32.rd_addr), 32'd0);
    check("t5_out_valid", 32'(b32.out_valid), 32'd0);
    check("t5_out_data", 32'(b32.out_data), 32'd0);
    check("t5_out_index", 32'(b32.out_index), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    acc_q.delete();
    start32(t0);
    wait_done32(t1);
    @(negedge clk);
    check_full_stream("t5");

    // Two-register instance.
    acc2_q.delete(); d0 = done2_cnt;
    @(negedge clk);
    b2.start = 1'b1;
    @(negedge clk);
    b2.start = 1'b0;
    begin
      int k = 0;
      while (!b2.done && k < 50) begin @(negedge clk); k++; end
    end
    check("t6_done_seen", 32'(b2.done), 32'd1);
    repeat (5) @(negedge clk);
    check("t6_count", 32'(acc2_q.size()), 32'd2);
    check("t6_byte0", 32'(acc2_q[0]), 32'({5'd0, regs[0]}));
    check("t6_byte1", 32'(acc2_q[1]), 32'({5'd1, regs[1]}));
    check("t6_done_pulses", 32'(done2_cnt - d0), 32'd1);
    check("t6_max_rd_addr", 32'(max_addr2), 32'd1);

    // Randomized traffic: ready jitter, stray starts and occasional aborts.
    repeat (4000) begin
      @(negedge clk);
      b32.out_ready = ($urandom_range(0, 3) != 0);
      b32.start = ($urandom_range(0, 15) == 0);
      b32.abort = ($urandom_range(0, 199) == 0);
      if (!b32.busy) regs[$urandom_range(0, 31)] = 8'($urandom);
    end
    @(negedge clk);
    b32.start = 1'b0; b32.abort = 1'b0; b32.out_ready = 1'b1;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
